// File: rtl/stream_mux_rr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : stream_mux_rr_pkg                                           |
// | Brief  : Shared constants and helpers for the stream multiplexer     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package stream_mux_rr_pkg;

  // Arbitration modes selectable through the ARB_MODE parameter
  localparam int ARB_SELECT = 0;
  localparam int ARB_RR     = 1;

  // Ceiling log2 for elaboration-time width derivation
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_mux_rr_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : stream_mux_rr_if                                            |
// | Brief  : Producer-side and consumer-side handshake bundle of the mux |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface stream_mux_rr_if
  import stream_mux_rr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4
);
  localparam int SEL_W = clog2(N_CH);

  logic [N_CH-1:0]       in_valid;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_ready;
  logic [SEL_W-1:0]      sel;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_channel;
  logic                  out_ready;

  // Mux side
  modport slave (
    input  in_valid, in_data, sel, out_ready,
    output in_ready, out_valid, out_data, out_channel
  );

  // Producers and downstream consumer side
  modport master (
    output in_valid, in_data, sel, out_ready,
    input  in_ready, out_valid, out_data, out_channel
  );
endinterface
`default_nettype wire

// File: rtl/stream_mux_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rr_arbiter                                                  |
// | Brief  : Combinational round-robin arbiter; pointer marks the first  |
// |          candidate, search wraps through a doubled request vector    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module rr_arbiter
  import stream_mux_rr_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int SEL_W = clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] idx
);

  logic [N_CH-1:0]   w_masked;
  logic [2*N_CH-1:0] w_dbl;
  logic              w_found;

  // Lower half holds requests at or above ptr, upper half the full set,
  // so the first set bit of the doubled vector is the round-robin winner.
  always_comb begin
    w_masked = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_masked[i] = req[i] && (SEL_W'(i) >= ptr);
    end
    w_dbl   = {req, w_masked};
    w_found = 1'b0;
    idx     = '0;
    for (int j = 0; j < 2*N_CH; j++) begin
      if (!w_found && w_dbl[j]) begin
        w_found = 1'b1;
        idx     = SEL_W'(j % N_CH);
      end
    end
    grant = '0;
    for (int i = 0; i < N_CH; i++) begin
      grant[i] = w_found && (idx == SEL_W'(i));
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : stream_mux_rr                                               |
// | Brief  : N-channel registered stream mux, external select or         |
// |          round-robin arbitration, single output stage w/ backpressure|
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int N_CH     = 4,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_mux_rr_if.slave bus
);
  localparam int SEL_W = clog2(N_CH);

  logic [N_CH-1:0]  w_grant;
  logic [SEL_W-1:0] w_idx;
  logic             w_load;
  logic             w_xfer;
  logic [WIDTH-1:0] w_mux_data;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_channel;

  // The output stage can take a word when empty or being drained now.
  // in_ready is therefore combinational from out_ready and in_valid.
  assign w_load = ~r_out_valid | bus.out_ready;
  assign w_xfer = w_load & (|w_grant);

  generate
    if (ARB_MODE == ARB_RR) begin : g_rr
      logic [SEL_W-1:0] r_ptr;
      logic             w_unused_sel;

      assign w_unused_sel = ^bus.sel;

      rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req   (bus.in_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx)
      );

      // Pointer moves past the winner only on a real transfer, so a stall never skips a channel
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ptr <= '0;
        end else if (w_xfer) begin
          r_ptr <= (w_idx == SEL_W'(N_CH-1)) ? '0 : w_idx + 1'b1;
        end
      end
    end else begin : g_sel
      // Out-of-range select values match no channel and yield no grant
      always_comb begin
        w_grant = '0;
        for (int i = 0; i < N_CH; i++) begin
          w_grant[i] = bus.in_valid[i] && (bus.sel == SEL_W'(i));
        end
      end
      assign w_idx = bus.sel;
    end
  endgenerate

  // AND-OR data selection; grant is one-hot or zero
  always_comb begin
    w_mux_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_mux_data = w_mux_data | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
    end
  end

  // Output register: capture winner on load, empty on load without a winner, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_channel <= '0;
    end else if (w_load) begin
      if (w_xfer) begin
        r_out_valid   <= 1'b1;
        r_out_data    <= w_mux_data;
        r_out_channel <= w_idx;
      end else begin
        r_out_valid   <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = {N_CH{w_load}} & w_grant;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.out_channel = r_out_channel;

endmodule
`default_nettype wire
